// File: rtl/boom_pkg.sv
// Shared definitions for the boom subsystem (movement engine and launch judge).
// Holds direction encodings, field limits, the launch-judge state encoding and
// the owner encoding carried on the owner bus.
package boom_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    localparam int unsigned X_MAX = 38;
    localparam int unsigned Y_MAX = 28;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_FLIGHT   = 2'd2,
        S_COOLDOWN = 2'd3
    } state_e;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_P1   = 2'd1;
    localparam logic [1:0] OWNER_P2   = 2'd2;

endpackage

// File: rtl/boom_hit_cmp.sv
// Combinational match of three engine booms against one head position.
// A boom only matches while it is inside the field and not already consumed.
// Ports:
//   boomN_x_i/boomN_y_i : boom N position (N = 1..3)
//   head_x_i/head_y_i   : head position under test
//   outside_i[2:0]      : boom has left the field
//   kill_i[2:0]         : boom already consumed this flight
//   match_o[2:0]        : per-boom live match
module boom_hit_cmp (
    input  logic [5:0] boom1_x_i,
    input  logic [5:0] boom1_y_i,
    input  logic [5:0] boom2_x_i,
    input  logic [5:0] boom2_y_i,
    input  logic [5:0] boom3_x_i,
    input  logic [5:0] boom3_y_i,
    input  logic [5:0] head_x_i,
    input  logic [5:0] head_y_i,
    input  logic [2:0] outside_i,
    input  logic [2:0] kill_i,
    output logic [2:0] match_o
);

    logic [2:0] pos_eq;

    always_comb begin
        pos_eq    = 3'b000;
        pos_eq[0] = (boom1_x_i == head_x_i) && (boom1_y_i == head_y_i);
        pos_eq[1] = (boom2_x_i == head_x_i) && (boom2_y_i == head_y_i);
        pos_eq[2] = (boom3_x_i == head_x_i) && (boom3_y_i == head_y_i);
        match_o   = pos_eq & ~outside_i & ~kill_i;
    end

endmodule

// File: rtl/boom_launch_judge.sv
// Launch arbiter and hit judge for the two-player boom game.
// Edge-detects fire buttons, arbitrates round-robin between players, issues a
// one-cycle launch pulse, tracks the flight until the engine reports completion
// (or a timeout), scores hits of live booms against the opponent's head and
// enforces a cooldown before the next launch.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   fire1, fire2               : debounced fire button levels
//   head_x1/y1, head_x2/y2     : player head positions
//   boomN_x/y, outsideN        : engine boom positions and out-of-field flags
//   ready_next_boom            : engine flight-complete pulse
//   boom_active1/2             : launch pulse per player
//   boom_kill                  : booms consumed during the current flight
//   owner                      : current shooter (0 none, 1 p1, 2 p2)
//   hit1/hit2                  : one-cycle hit pulse per victim
//   hit_cnt1/2, dead1/2        : saturating hit counters and sticky dead flags
//   busy                       : not idle
module boom_launch_judge
    import boom_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYCLES = 25,
    parameter int unsigned FLIGHT_TIMEOUT  = 4096,
    parameter int unsigned MAX_HITS        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fire1,
    input  logic       fire2,
    input  logic [5:0] head_x1,
    input  logic [5:0] head_y1,
    input  logic [5:0] head_x2,
    input  logic [5:0] head_y2,
    input  logic [5:0] boom1_x,
    input  logic [5:0] boom1_y,
    input  logic [5:0] boom2_x,
    input  logic [5:0] boom2_y,
    input  logic [5:0] boom3_x,
    input  logic [5:0] boom3_y,
    input  logic       outside1,
    input  logic       outside2,
    input  logic       outside3,
    input  logic       ready_next_boom,
    output logic       boom_active1,
    output logic       boom_active2,
    output logic [2:0] boom_kill,
    output logic [1:0] owner,
    output logic       hit1,
    output logic       hit2,
    output logic [1:0] hit_cnt1,
    output logic [1:0] hit_cnt2,
    output logic       dead1,
    output logic       dead2,
    output logic       busy
);

    localparam int unsigned FlW = (FLIGHT_TIMEOUT > 2) ? $clog2(FLIGHT_TIMEOUT) : 1;
    localparam int unsigned CdW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    // Bit 0 is player1, bit 1 is player2 in all two-bit player vectors.
    state_e           state_q, state_d;
    logic [1:0]       fire_q, fire_prev_q;
    logic [1:0]       pend_q, pend_d;
    logic             rr_q, rr_d;        // 0: player1 wins a tie, 1: player2
    logic [1:0]       owner_q, owner_d;
    logic [2:0]       kill_q, kill_d;
    logic [1:0]       hit_q, hit_d;
    logic [1:0]       cnt1_q, cnt1_d;
    logic [1:0]       cnt2_q, cnt2_d;
    logic [1:0]       dead_q, dead_d;
    logic [FlW-1:0]   flight_cnt_q, flight_cnt_d;
    logic [CdW-1:0]   cool_cnt_q, cool_cnt_d;

    logic [1:0]       fire_edge;
    logic [1:0]       req;
    logic [1:0]       win_mask;
    logic [5:0]       opp_x, opp_y;
    logic [2:0]       match;

    assign fire_edge = fire_q & ~fire_prev_q;
    assign req       = (fire_edge | pend_q) & ~dead_q;

    // The opponent of the current shooter is the only head under test.
    assign opp_x = (owner_q == OWNER_P2) ? head_x1 : head_x2;
    assign opp_y = (owner_q == OWNER_P2) ? head_y1 : head_y2;

    boom_hit_cmp u_hit_cmp (
        .boom1_x_i (boom1_x),
        .boom1_y_i (boom1_y),
        .boom2_x_i (boom2_x),
        .boom2_y_i (boom2_y),
        .boom3_x_i (boom3_x),
        .boom3_y_i (boom3_y),
        .head_x_i  (opp_x),
        .head_y_i  (opp_y),
        .outside_i ({outside3, outside2, outside1}),
        .kill_i    (kill_q),
        .match_o   (match)
    );

    always_comb begin
        state_d      = state_q;
        pend_d       = (pend_q | fire_edge) & ~dead_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        kill_d       = kill_q;
        hit_d        = 2'b00;
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;
        dead_d       = dead_q;
        flight_cnt_d = flight_cnt_q;
        cool_cnt_d   = cool_cnt_q;
        win_mask     = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    if (req == 2'b11) begin
                        win_mask = rr_q ? 2'b10 : 2'b01;
                        rr_d     = ~rr_q;
                    end else begin
                        win_mask = req;
                    end
                    owner_d = win_mask[1] ? OWNER_P2 : OWNER_P1;
                    // Loser keeps its request latched for the next idle slot.
                    pend_d  = req & ~win_mask;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                kill_d       = 3'b000;
                flight_cnt_d = '0;
                state_d      = S_FLIGHT;
            end
            S_FLIGHT: begin
                flight_cnt_d = flight_cnt_q + FlW'(1);
                if (|match) begin
                    kill_d = kill_q | match;
                    if (owner_q == OWNER_P2) begin
                        hit_d[0] = 1'b1;
                        if (cnt1_q != 2'd3) cnt1_d = cnt1_q + 2'd1;
                    end else begin
                        hit_d[1] = 1'b1;
                        if (cnt2_q != 2'd3) cnt2_d = cnt2_q + 2'd1;
                    end
                end
                // A hit in the exit cycle is still scored above.
                if (ready_next_boom || (flight_cnt_q == FlW'(FLIGHT_TIMEOUT - 1))) begin
                    owner_d    = OWNER_NONE;
                    cool_cnt_d = '0;
                    state_d    = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cool_cnt_q == CdW'(COOLDOWN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cool_cnt_d = cool_cnt_q + CdW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        dead_d[0] = dead_q[0] | (32'(cnt1_d) >= MAX_HITS);
        dead_d[1] = dead_q[1] | (32'(cnt2_d) >= MAX_HITS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fire_q       <= 2'b00;
            fire_prev_q  <= 2'b00;
            pend_q       <= 2'b00;
            rr_q         <= 1'b0;
            owner_q      <= OWNER_NONE;
            kill_q       <= 3'b000;
            hit_q        <= 2'b00;
            cnt1_q       <= 2'd0;
            cnt2_q       <= 2'd0;
            dead_q       <= 2'b00;
            flight_cnt_q <= '0;
            cool_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fire_q       <= {fire2, fire1};
            fire_prev_q  <= fire_q;
            pend_q       <= pend_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            kill_q       <= kill_d;
            hit_q        <= hit_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            dead_q       <= dead_d;
            flight_cnt_q <= flight_cnt_d;
            cool_cnt_q   <= cool_cnt_d;
        end
    end

    assign boom_active1 = (state_q == S_LAUNCH) && (owner_q == OWNER_P1);
    assign boom_active2 = (state_q == S_LAUNCH) && (owner_q == OWNER_P2);
    assign boom_kill    = kill_q;
    assign owner        = owner_q;
    assign hit1         = hit_q[0];
    assign hit2         = hit_q[1];
    assign hit_cnt1     = cnt1_q;
    assign hit_cnt2     = cnt2_q;
    assign dead1        = dead_q[0];
    assign dead2        = dead_q[1];
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_boom_launch_judge.sv
// Self-checking bench for boom_launch_judge: expected launches and hits are
// queued as stimulus is applied and popped when the DUT pulses them.
module tb_boom_launch_judge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fire1, fire2;
    logic [5:0] head_x1, head_y1, head_x2, head_y2;
    logic [5:0] boom1_x, boom1_y, boom2_x, boom2_y, boom3_x, boom3_y;
    logic       outside1, outside2, outside3;
    logic       ready_next_boom;
    logic       boom_active1, boom_active2;
    logic [2:0] boom_kill;
    logic [1:0] owner;
    logic       hit1, hit2;
    logic [1:0] hit_cnt1, hit_cnt2;
    logic       dead1, dead2;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;
    int launch_q[$];
    int hit_q[$];

    always #5 clk = ~clk;

    boom_launch_judge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fire1           (fire1),
        .fire2           (fire2),
        .head_x1         (head_x1),
        .head_y1         (head_y1),
        .head_x2         (head_x2),
        .head_y2         (head_y2),
        .boom1_x         (boom1_x),
        .boom1_y         (boom1_y),
        .boom2_x         (boom2_x),
        .boom2_y         (boom2_y),
        .boom3_x         (boom3_x),
        .boom3_y         (boom3_y),
        .outside1        (outside1),
        .outside2        (outside2),
        .outside3        (outside3),
        .ready_next_boom (ready_next_boom),
        .boom_active1    (boom_active1),
        .boom_active2    (boom_active2),
        .boom_kill       (boom_kill),
        .owner           (owner),
        .hit1            (hit1),
        .hit2            (hit2),
        .hit_cnt1        (hit_cnt1),
        .hit_cnt2        (hit_cnt2),
        .dead1           (dead1),
        .dead2           (dead2),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every launch/hit pulse must match the queued order.
    always @(negedge clk) begin
        int who;
        if (boom_active1 || boom_active2) begin
            who = boom_active1 ? 1 : 2;
            check("launch_excl", {31'd0, boom_active1 & boom_active2}, 0);
            if (launch_q.size() == 0) check("launch_who", who, 0);
            else check("launch_who", who, launch_q.pop_front());
        end
        if (hit1 || hit2) begin
            who = hit1 ? 1 : 2;
            check("hit_excl", {31'd0, hit1 & hit2}, 0);
            if (hit_q.size() == 0) check("hit_who", who, 0);
            else check("hit_who", who, hit_q.pop_front());
        end
    end

    task automatic wait_launch(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(boom_active1 || boom_active2) && n < bound);
        if (!(boom_active1 || boom_active2)) check("launch_seen", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 0);
    endtask

    task automatic pulse_ready();
        ready_next_boom = 1'b1;
        @(negedge clk);
        ready_next_boom = 1'b0;
    endtask

    // Fire one player from idle; returns at the first flight cycle.
    task automatic launch(input int p, output int lat);
        if (p == 1) fire1 = 1'b1;
        else fire2 = 1'b1;
        launch_q.push_back(p);
        wait_launch(20, lat);
        check("launch_owner", {30'd0, owner}, p);
        fire1 = 1'b0;
        fire2 = 1'b0;
        @(negedge clk);
        check("pulse_width", {30'd0, boom_active2, boom_active1}, 0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n = 1'b0;
        fire1 = 1'b0; fire2 = 1'b0;
        head_x1 = 6'd5;  head_y1 = 6'd7;
        head_x2 = 6'd10; head_y2 = 6'd12;
        boom1_x = 6'd0; boom1_y = 6'd0;
        boom2_x = 6'd0; boom2_y = 6'd0;
        boom3_x = 6'd0; boom3_y = 6'd0;
        outside1 = 1'b1; outside2 = 1'b1; outside3 = 1'b1;
        ready_next_boom = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy", {31'd0, busy}, 0);
        check("rst_owner", {30'd0, owner}, 0);
        check("rst_kill", {29'd0, boom_kill}, 0);
        check("rst_cnt", {28'd0, hit_cnt2, hit_cnt1}, 0);
        check("rst_dead", {30'd0, dead2, dead1}, 0);
        check("rst_active", {30'd0, boom_active2, boom_active1}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single launch, clean flight, 25-cycle cooldown.
        launch(1, lat);
        check("launch_lat", lat, 2);
        check("flight_owner", {30'd0, owner}, 1);
        pulse_ready();
        check("cool_owner", {30'd0, owner}, 0);
        repeat (24) @(negedge clk);
        check("cool_busy24", {31'd0, busy}, 1);
        @(negedge clk);
        check("cool_busy25", {31'd0, busy}, 0);

        // Simultaneous fire: p1 first, p2 auto-launched after cooldown.
        fire1 = 1'b1; fire2 = 1'b1;
        launch_q.push_back(1); launch_q.push_back(2);
        wait_launch(20, lat);
        fire1 = 1'b0; fire2 = 1'b0;
        @(negedge clk);
        pulse_ready();
        wait_launch(80, lat);
        check("auto_owner", {30'd0, owner}, 2);
        @(negedge clk);
        pulse_ready();
        wait_idle(60);
        // Next tie goes to p2.
        fire1 = 1'b1; fire2 = 1'b1;
        launch_q.push_back(2); launch_q.push_back(1);
        wait_launch(20, lat);
        fire1 = 1'b0; fire2 = 1'b0;
        @(negedge clk);
        pulse_ready();
        wait_launch(80, lat);
        @(negedge clk);
        pulse_ready();
        wait_idle(60);

        // Direct hit on p2 with boom2, then held for 5 cycles.
        launch(1, lat);
        boom2_x = 6'd10; boom2_y = 6'd12; outside2 = 1'b0;
        hit_q.push_back(2);
        @(negedge clk);
        check("hit_cnt2_a", {30'd0, hit_cnt2}, 1);
        check("kill_a", {29'd0, boom_kill}, 3'b010);
        repeat (5) @(negedge clk);
        check("hold_cnt2", {30'd0, hit_cnt2}, 1);
        outside2 = 1'b1;

        // Masked boom and self-head are ignored.
        boom1_x = 6'd10; boom1_y = 6'd12;
        repeat (3) @(negedge clk);
        check("masked_cnt2", {30'd0, hit_cnt2}, 1);
        boom3_x = 6'd5; boom3_y = 6'd7; outside3 = 1'b0;
        repeat (3) @(negedge clk);
        check("self_cnt1", {30'd0, hit_cnt1}, 0);
        check("self_kill", {29'd0, boom_kill}, 3'b010);
        outside3 = 1'b1;
        pulse_ready();
        wait_idle(60);

        // Two booms on p2's head at once: one hit, both killed.
        launch(1, lat);
        check("kill_cleared", {29'd0, boom_kill}, 0);
        boom2_x = 6'd10; boom2_y = 6'd12;
        outside1 = 1'b0; outside2 = 1'b0;
        hit_q.push_back(2);
        @(negedge clk);
        check("dual_cnt2", {30'd0, hit_cnt2}, 2);
        check("dual_kill", {29'd0, boom_kill}, 3'b011);
        check("dual_dead2", {31'd0, dead2}, 0);
        outside1 = 1'b1; outside2 = 1'b1;
        pulse_ready();
        wait_idle(60);

        // Third and fourth hits: saturation and dead.
        launch(1, lat);
        outside1 = 1'b0;
        hit_q.push_back(2);
        @(negedge clk);
        check("hit3_cnt2", {30'd0, hit_cnt2}, 3);
        check("hit3_dead2", {31'd0, dead2}, 1);
        outside1 = 1'b1;
        boom3_x = 6'd10; boom3_y = 6'd12; outside3 = 1'b0;
        hit_q.push_back(2);
        @(negedge clk);
        check("hit4_cnt2", {30'd0, hit_cnt2}, 3);
        check("hit4_dead", {30'd0, dead2, dead1}, 2'b10);
        outside3 = 1'b1;
        pulse_ready();
        wait_idle(60);

        // Dead player's fire is ignored.
        fire2 = 1'b1;
        repeat (20) @(negedge clk);
        check("dead_fire_busy", {31'd0, busy}, 0);
        fire2 = 1'b0;

        // Flight timeout: owner stays set for launch + 4096 flight cycles.
        launch(1, lat);
        n = 2;
        do begin
            @(negedge clk);
            if (owner != 2'd0) n++;
        end while (owner != 2'd0 && n < 5000);
        check("timeout_len", n, 4097);
        check("timeout_cool", {31'd0, busy}, 1);
        wait_idle(60);

        // Reset mid-flight.
        launch(1, lat);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_owner", {30'd0, owner}, 0);
        check("mid_rst_cnt2", {30'd0, hit_cnt2}, 0);
        check("mid_rst_dead2", {31'd0, dead2}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("launch_q_left", launch_q.size(), 0);
        check("hit_q_left", hit_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/boom_launch_judge.md
Name: boom_launch_judge

Overview:
- Control-side partner of the boom movement engine.
- Edge-detects player fire buttons and arbitrates between players. Issues the one-cycle boom_active1/boom_active2 launch pulse, then tracks the flight until the engine reports ready_next_boom.
- During flight, compares every live boom against the opponent's head, emits hit events and maintains saturating per-player hit counters.
- Sits between the player input/keypad logic and boom_movement; its outputs feed the score and display logic.

Parameters:
- COOLDOWN_CYCLES, 25, idle cycles enforced after a flight ends before the next launch (board build overrides to 12_500_000).
- FLIGHT_TIMEOUT, 4096, cycles in S_FLIGHT without ready_next_boom before forced abort.
- MAX_HITS, 3, hit count at which a player is flagged dead.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- fire1, in, 1, player1 fire button, level, already debounced.
- fire2, in, 1, player2 fire button, level, already debounced.
- head_x1, in, 6, player1 head column.
- head_y1, in, 6, player1 head row.
- head_x2, in, 6, player2 head column.
- head_y2, in, 6, player2 head row.
- boom1_x, in, 6, engine boom1 column; boom1_y, in, 6, engine boom1 row.
- boom2_x, in, 6, engine boom2 column; boom2_y, in, 6, engine boom2 row.
- boom3_x, in, 6, engine boom3 column; boom3_y, in, 6, engine boom3 row.
- outside1, outside2, outside3, in, 1 each, engine "boom left field" flags.
- ready_next_boom, in, 1, engine flight-complete pulse.
- boom_active1, out, 1, launch pulse for player1.
- boom_active2, out, 1, launch pulse for player2.
- boom_kill, out, 3, per-boom consumed mask; display hides these booms.
- owner, out, 2, 0 none, 1 player1, 2 player2.
- hit1, out, 1, one-cycle pulse when player1 is hit.
- hit2, out, 1, one-cycle pulse when player2 is hit.
- hit_cnt1, out, 2, player1 hits taken, saturating.
- hit_cnt2, out, 2, player2 hits taken, saturating.
- dead1, out, 1, sticky: hit_cnt1 has reached MAX_HITS.
- dead2, out, 1, sticky: hit_cnt2 has reached MAX_HITS.
- busy, out, 1, high in any state except S_IDLE.

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters 0, edge registers 0, round-robin pointer set to player1.
- Fire detection: rising edge of fire1 or fire2, registered against the previous sample.
  - An edge seen outside S_IDLE is latched as a pending request, one per player.
  - Only one pending request is kept per player; later edges are absorbed.
  - A request from a dead player is ignored.
- S_IDLE:
  - If any request is pending (edge this cycle or latched), grant it and go to S_LAUNCH.
  - If both players request, the round-robin pointer wins and the pointer then flips to the other player.
  - The winner's pending request is cleared; the loser's stays latched.
- S_LAUNCH, exactly 1 cycle:
  - boom_active of the winner is 1; owner is set to the winner.
  - boom_kill is cleared; flight counter is cleared.
  - Next state is S_FLIGHT.
- S_FLIGHT:
  - Engine positions are valid from the first S_FLIGHT cycle.
  - Per boom k, check every cycle: if outside_k==0, boom_kill[k]==0, and boom_k equals the opponent head (x and y), then:
    - set boom_kill[k];
    - pulse the opponent's hit on the next cycle;
    - increment the opponent's hit_cnt.
  - The shooter's own head is never checked.
  - Several booms matching in the same cycle produce one hit pulse and one increment; all matching booms are killed.
  - hit_cnt saturates at 3; dead asserts when hit_cnt reaches MAX_HITS and stays set until reset.
  - Exit to S_COOLDOWN on ready_next_boom==1, or when the flight counter reaches FLIGHT_TIMEOUT-1 (abort).
- S_COOLDOWN:
  - Count COOLDOWN_CYCLES cycles, then go to S_IDLE.
  - On entry owner returns to 0; boom_kill holds until the next S_LAUNCH.
- A hit and ready_next_boom in the same cycle: the hit is counted, then the block leaves S_FLIGHT.
- Reset mid-flight: everything returns to reset values; the engine is reset by the same rst_n.
- Coordinate compares are 6-bit equality with no wrap handling; the engine's outside flags define validity.

Decomposition:
- Shared package boom_pkg:
  - direction encodings UP=0, DOWN=1, LEFT=2, RIGHT=3;
  - field limits X_MAX=38, Y_MAX=28;
  - state enum S_IDLE, S_LAUNCH, S_FLIGHT, S_COOLDOWN;
  - owner encodings.
- One sub-module, boom_hit_cmp: combinational match of 3 booms against 1 head with outside and kill masks; outputs a 3-bit match vector.

Test Plan:
- Single launch and clean flight:
  - Stimulus: fire1 rising with the block idle.
  - Required: boom_active1=1 for exactly 1 cycle, 1 cycle after the edge registers; owner=1.
  - Drive ready_next_boom: COOLDOWN_CYCLES=25 cycles later busy=0.
- Simultaneous fire:
  - Stimulus: fire1 and fire2 rise in the same cycle after reset.
  - Required: player1 launches first; player2 launches automatically after the flight and cooldown.
  - Required: the next simultaneous pair launches player2 first.
- Direct hit:
  - Stimulus: owner=1, head2=(10,12), boom2=(10,12), outside2=0.
  - Required: hit2 pulses once, hit_cnt2=1, boom_kill=3'b010.
  - Holding the same coordinates for 5 cycles produces no further increment.
- Masked and self cases:
  - Stimulus 1: boom1 equals head2 with outside1=1. Required: no hit.
  - Stimulus 2: boom equals head1 while owner=1. Required: no hit.
  - Stimulus 3: two booms match head2 in the same cycle. Required: one hit2 pulse, hit_cnt2 increments by 1, boom_kill=3'b011 (both matching booms killed).
- Saturation and dead:
  - Stimulus: apply 4 separate hits on player2.
  - Required: hit_cnt2=3, dead2=1 after the third hit.
  - A subsequent fire2 edge is ignored: no boom_active2.
- Timeout and reset:
  - Stimulus: withhold ready_next_boom for FLIGHT_TIMEOUT cycles. Required: S_COOLDOWN entered.
  - Stimulus: rst_n=0 for one clock mid-flight. Required: all outputs 0 on the next edge.
